// File: rtl/axis_rgb_packer_if.sv
// Pixel-side and AXI4-Stream word-side bundles used by axis_rgb_packer.
// Signal names match the packer's pin names so the wiring reads one-to-one.
interface pix_stream_if;
  logic [7:0] in_r;
  logic [7:0] in_g;
  logic [7:0] in_b;
  logic       in_valid;
  logic       in_eol;
  logic       in_sof;
  logic       in_ready;

  modport master (output in_r, in_g, in_b, in_valid, in_eol, in_sof, input in_ready);
  modport slave  (input in_r, in_g, in_b, in_valid, in_eol, in_sof, output in_ready);
endinterface

interface axis_word_if;
  logic [31:0] m_axis_tdata;
  logic        m_axis_tvalid;
  logic        m_axis_tready;
  logic        m_axis_tlast;
  logic        m_axis_tuser;

  modport master (output m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                  input m_axis_tready);
  modport slave  (input m_axis_tdata, m_axis_tvalid, m_axis_tlast, m_axis_tuser,
                  output m_axis_tready);
endinterface

// File: rtl/axis_rgb_packer.sv
// Packs 24-bit RGB pixels densely into 32-bit AXI4-Stream words (4 pixels -> 3 words).
// EOL flushes a padded partial word with TLAST; SOF marks the first word with TUSER.
module axis_rgb_packer #(
  parameter logic [7:0] PAD_BYTE = 8'h00
) (
  input  logic         aclk,
  input  logic         areset,
  pix_stream_if.slave  pix,
  axis_word_if.master  axis,
  output logic         sof_misalign
);

  localparam logic [0:0] ST_RUN   = 1'b0;
  localparam logic [0:0] ST_FLUSH = 1'b1;

  logic [0:0]  state_q,  state_d;
  logic [1:0]  fill_q,   fill_d;
  logic [23:0] res_q,    res_d;
  logic        res_sof_q, res_sof_d;
  logic [31:0] tdata_q,  tdata_d;
  logic        tvalid_q, tvalid_d;
  logic        tlast_q,  tlast_d;
  logic        tuser_q,  tuser_d;
  logic        mis_q,    mis_d;

  logic        out_free;
  logic        in_ready;
  logic        accept;
  logic [1:0]  eff_fill;
  logic [23:0] eff_res;
  logic [23:0] pix_bytes;
  logic [47:0] merged;
  logic [1:0]  rem;

  // Lowest n bytes of src kept, remaining lanes filled with PAD_BYTE.
  function automatic logic [31:0] pad_word(input logic [23:0] src, input logic [1:0] n);
    logic [31:0] w;
    w = {4{PAD_BYTE}};
    for (int i = 0; i < 3; i++) begin
      if (2'(i) < n) w[8*i +: 8] = src[8*i +: 8];
    end
    return w;
  endfunction

  assign out_free  = !tvalid_q || axis.m_axis_tready;
  assign in_ready  = (state_q == ST_RUN) && out_free;
  assign accept    = pix.in_valid && in_ready;
  // An SOF pixel always restarts packing at lane 0, dropping any residue.
  assign eff_fill  = pix.in_sof ? 2'd0 : fill_q;
  assign eff_res   = pix.in_sof ? 24'd0 : res_q;
  assign pix_bytes = {pix.in_b, pix.in_g, pix.in_r};
  assign merged    = {24'd0, eff_res} | ({24'd0, pix_bytes} << {eff_fill, 3'b000});
  assign rem       = eff_fill - 2'd1;

  always_comb begin
    state_d   = state_q;
    fill_d    = fill_q;
    res_d     = res_q;
    res_sof_d = res_sof_q;
    tdata_d   = tdata_q;
    tvalid_d  = tvalid_q;
    tlast_d   = tlast_q;
    tuser_d   = tuser_q;
    mis_d     = 1'b0;

    if (tvalid_q && axis.m_axis_tready) tvalid_d = 1'b0;

    if (accept) begin
      mis_d = pix.in_sof && (fill_q != 2'd0);
      if (eff_fill == 2'd0) begin
        if (pix.in_eol) begin
          tdata_d   = pad_word(pix_bytes, 2'd3);
          tvalid_d  = 1'b1;
          tlast_d   = 1'b1;
          tuser_d   = pix.in_sof;
          fill_d    = 2'd0;
          res_d     = 24'd0;
          res_sof_d = 1'b0;
        end else begin
          res_d     = pix_bytes;
          fill_d    = 2'd3;
          res_sof_d = pix.in_sof;
        end
      end else begin
        tdata_d   = merged[31:0];
        tvalid_d  = 1'b1;
        tuser_d   = res_sof_q;
        tlast_d   = 1'b0;
        res_d     = {8'd0, merged[47:32]};
        fill_d    = rem;
        res_sof_d = 1'b0;
        if (pix.in_eol) begin
          if (rem == 2'd0) tlast_d = 1'b1;
          else             state_d = ST_FLUSH;
        end
      end
    end else if (state_q == ST_FLUSH && out_free) begin
      tdata_d   = pad_word(res_q, fill_q);
      tvalid_d  = 1'b1;
      tlast_d   = 1'b1;
      tuser_d   = res_sof_q;
      fill_d    = 2'd0;
      res_d     = 24'd0;
      res_sof_d = 1'b0;
      state_d   = ST_RUN;
    end
  end

  always_ff @(posedge aclk or posedge areset) begin
    if (areset) begin
      state_q   <= ST_RUN;
      fill_q    <= 2'd0;
      res_q     <= 24'd0;
      res_sof_q <= 1'b0;
      tdata_q   <= 32'd0;
      tvalid_q  <= 1'b0;
      tlast_q   <= 1'b0;
      tuser_q   <= 1'b0;
      mis_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      fill_q    <= fill_d;
      res_q     <= res_d;
      res_sof_q <= res_sof_d;
      tdata_q   <= tdata_d;
      tvalid_q  <= tvalid_d;
      tlast_q   <= tlast_d;
      tuser_q   <= tuser_d;
      mis_q     <= mis_d;
    end
  end

  assign pix.in_ready       = in_ready;
  assign axis.m_axis_tdata  = tdata_q;
  assign axis.m_axis_tvalid = tvalid_q;
  assign axis.m_axis_tlast  = tlast_q;
  assign axis.m_axis_tuser  = tuser_q;
  assign sof_misalign       = mis_q;

endmodule

// File: tb/tb_axis_rgb_packer.sv
// Directed bench for axis_rgb_packer: byte-level reference model feeds a word
// scoreboard that a negedge monitor drains as the DUT hands words to the sink.
module tb_axis_rgb_packer;

  logic aclk = 1'b0;
  logic areset = 1'b1;
  logic sof_misalign;

  always #5 aclk = ~aclk;

  pix_stream_if pix ();
  axis_word_if  axis ();

  axis_rgb_packer #(.PAD_BYTE(8'h00)) dut (
    .aclk         (aclk),
    .areset       (areset),
    .pix          (pix),
    .axis         (axis),
    .sof_misalign (sof_misalign)
  );

  int errors = 0;
  int checks = 0;
  int stall_cnt = 0;
  int mis_cnt = 0;
  int exp_mis = 0;

  logic [33:0] exp_q[$];   // {tdata, tlast, tuser}
  logic [7:0]  mbytes[$];
  bit          msof_pend = 1'b0;

  task automatic check(input string tag, input logic [33:0] obs, input logic [33:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference model: flat byte stream, cut into 4-byte words.
  task automatic model_pix(input logic [7:0] r, g, b, input logic eol, sof);
    logic [31:0] w;
    if (sof) begin
      if (mbytes.size() != 0) exp_mis++;
      mbytes.delete();
      msof_pend = 1'b1;
    end
    mbytes.push_back(r);
    mbytes.push_back(g);
    mbytes.push_back(b);
    while (mbytes.size() >= 4) begin
      for (int i = 0; i < 4; i++) w[8*i +: 8] = mbytes.pop_front();
      exp_q.push_back({w, eol && (mbytes.size() == 0), msof_pend});
      msof_pend = 1'b0;
    end
    if (eol && mbytes.size() != 0) begin
      w = 32'h0000_0000;
      for (int i = 0; mbytes.size() != 0; i++) w[8*i +: 8] = mbytes.pop_front();
      exp_q.push_back({w, 1'b1, msof_pend});
      msof_pend = 1'b0;
    end
  endtask

  always @(negedge aclk) begin
    if (!areset) begin
      if (!pix.in_ready) stall_cnt++;
      if (sof_misalign) mis_cnt++;
      if (axis.m_axis_tvalid && axis.m_axis_tready) begin
        checks++;
        assert (exp_q.size() != 0)
        else begin
          errors++;
          $error("FAIL unexpected_word: got %h expected no word", axis.m_axis_tdata);
        end
        if (exp_q.size() != 0)
          check("word", {axis.m_axis_tdata, axis.m_axis_tlast, axis.m_axis_tuser},
                exp_q.pop_front());
      end
    end
  end

  task automatic send_pix(input logic [7:0] r, g, b, input logic eol, sof);
    int n = 0;
    bit done = 1'b0;
    pix.in_r = r; pix.in_g = g; pix.in_b = b;
    pix.in_eol = eol; pix.in_sof = sof; pix.in_valid = 1'b1;
    while (!done) begin
      @(negedge aclk);
      if (pix.in_ready) begin
        model_pix(r, g, b, eol, sof);
        done = 1'b1;
      end else if (++n > 50) begin
        errors++;
        $error("FAIL send_timeout: got in_ready=0 for 50 cycles expected acceptance");
        done = 1'b1;
      end
      @(posedge aclk);
      #1;
    end
    pix.in_valid = 1'b0;
  endtask

  task automatic drain(input string tag);
    int n = 0;
    while (exp_q.size() != 0 && n < 60) begin
      @(posedge aclk);
      n++;
    end
    @(posedge aclk);
    #1;
    check({"drain_", tag}, 34'(exp_q.size()), 34'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish expected finish before 200us");
    $fatal(1, "watchdog");
  end

  initial begin
    pix.in_valid = 1'b0; pix.in_r = '0; pix.in_g = '0; pix.in_b = '0;
    pix.in_eol = 1'b0; pix.in_sof = 1'b0;
    axis.m_axis_tready = 1'b1;

    #12;
    check("rst_tvalid", 34'(axis.m_axis_tvalid), 34'd0);
    check("rst_tdata",  34'(axis.m_axis_tdata),  34'd0);
    check("rst_tlast",  34'(axis.m_axis_tlast),  34'd0);
    check("rst_tuser",  34'(axis.m_axis_tuser),  34'd0);
    check("rst_mis",    34'(sof_misalign),       34'd0);
    check("rst_ready",  34'(pix.in_ready),       34'd1);
    @(posedge aclk); #1;
    areset = 1'b0;

    // Four pixels, no EOL, full rate.
    stall_cnt = 0;
    send_pix(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
    send_pix(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
    send_pix(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
    send_pix(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
    drain("nolast");
    check("nolast_stalls", 34'(stall_cnt), 34'd0);

    // Line width 1 with SOF.
    send_pix(8'h11, 8'h12, 8'h13, 1'b1, 1'b1);
    drain("width1");

    // Line width 2: one FLUSH cycle.
    stall_cnt = 0;
    send_pix(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
    send_pix(8'h21, 8'h22, 8'h23, 1'b1, 1'b0);
    drain("width2");
    check("width2_stalls", 34'(stall_cnt), 34'd1);

    // Backpressure: sink stalls 5 cycles after the first word.
    axis.m_axis_tready = 1'b0;
    send_pix(8'h11, 8'h12, 8'h13, 1'b0, 1'b0);
    send_pix(8'h21, 8'h22, 8'h23, 1'b0, 1'b0);
    fork
      begin
        send_pix(8'h31, 8'h32, 8'h33, 1'b0, 1'b0);
        send_pix(8'h41, 8'h42, 8'h43, 1'b0, 1'b0);
      end
      begin
        repeat (5) begin
          @(negedge aclk);
          check("bp_tdata",  34'(axis.m_axis_tdata),  34'h21131211);
          check("bp_tvalid", 34'(axis.m_axis_tvalid), 34'd1);
          check("bp_ready",  34'(pix.in_ready),       34'd0);
        end
        @(posedge aclk); #1;
        axis.m_axis_tready = 1'b1;
      end
    join
    drain("bp");

    // SOF arriving with one partial pixel held.
    mis_cnt = 0;
    exp_mis = 0;
    send_pix(8'h01, 8'h02, 8'h03, 1'b0, 1'b0);
    send_pix(8'h04, 8'h05, 8'h06, 1'b0, 1'b1);
    send_pix(8'h07, 8'h08, 8'h09, 1'b1, 1'b0);
    drain("misalign");
    check("misalign_model", 34'(exp_mis), 34'd1);
    check("misalign_pulses", 34'(mis_cnt), 34'(exp_mis));

    // Reset mid-line with fill=2 and a word pending.
    axis.m_axis_tready = 1'b0;
    send_pix(8'ha1, 8'ha2, 8'ha3, 1'b0, 1'b0);
    send_pix(8'hb1, 8'hb2, 8'hb3, 1'b0, 1'b0);
    check("pre_rst_tvalid", 34'(axis.m_axis_tvalid), 34'd1);
    #2;
    areset = 1'b1;
    #1;
    check("mid_rst_tvalid", 34'(axis.m_axis_tvalid), 34'd0);
    check("mid_rst_tdata",  34'(axis.m_axis_tdata),  34'd0);
    check("mid_rst_tlast",  34'(axis.m_axis_tlast),  34'd0);
    check("mid_rst_tuser",  34'(axis.m_axis_tuser),  34'd0);
    exp_q.delete();
    mbytes.delete();
    msof_pend = 1'b0;
    @(posedge aclk); #1;
    areset = 1'b0;
    axis.m_axis_tready = 1'b1;
    send_pix(8'h55, 8'h66, 8'h77, 1'b1, 1'b0);
    drain("post_rst");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axis_rgb_packer.md
Name: axis_rgb_packer

Overview:
- Downstream neighbour of the pixel buffer. It consumes one 24-bit RGB pixel per handshake, with EOL/SOF flags.
- It packs pixels densely into 32-bit AXI4-Stream video words (4 pixels -> 3 words) for the VDMA/stream interface.
- End-of-line flushes any partial word, padded, with TLAST. SOF maps to TUSER on the first word of the frame.

Parameters:
- PAD_BYTE, 8'h00, value written into unused byte lanes of a flushed partial word.

Ports:
- aclk  in  1  clock; all logic on rising edge.
- areset  in  1  asynchronous, active-high reset.
- in_r  in  8  red byte of the pixel.
- in_g  in  8  green byte.
- in_b  in  8  blue byte.
- in_valid  in  1  pixel present on in_r/g/b/eol/sof.
- in_eol  in  1  pixel is the last of its line.
- in_sof  in  1  pixel is the first of its frame.
- in_ready  out  1  packer accepts the pixel this cycle (drives upstream in_stream_ready).
- m_axis_tdata  out  32  packed word.
- m_axis_tvalid  out  1  word valid.
- m_axis_tready  in  1  sink ready.
- m_axis_tlast  out  1  last word of a line.
- m_axis_tuser  out  1  first word of a frame.
- sof_misalign  out  1  one-cycle pulse when SOF arrives while partial bytes are held.

Behaviour:
- Reset: areset=1 asynchronously clears all registers.
  - m_axis_tvalid, m_axis_tdata, m_axis_tlast, m_axis_tuser, sof_misalign = 0; state RUN; fill=0.
  - Releasing reset mid-line discards all partial data.
- Byte stream order per pixel: r, g, b. Stream byte n goes to tdata[8*(n mod 4)+7 : 8*(n mod 4)] (little-endian lanes).
- Residual register: up to 3 held bytes; fill in 0..3.
- Output register:
  - Single stage; holds the word, tlast and tuser until m_axis_tvalid && m_axis_tready.
  - tdata/tlast/tuser stay stable while tvalid=1 and tready=0.
- in_ready = (state==RUN) && (!m_axis_tvalid || m_axis_tready).
- Accepting a pixel (in_valid && in_ready), with total = fill+3:
  - total < 4 (fill=0): store 3 bytes; fill=3; no word.
  - total >= 4: load the output register next cycle with the lowest 4 bytes; residual = remaining total-4 bytes; fill = total-4. Latency is 1 cycle (word valid on the edge after acceptance).
  - tuser = 1 on the word containing the first byte of an SOF pixel.
- EOL handling when accepting an in_eol pixel, with residual after packing = r:
  - r==0 with a word emitted: that word gets tlast=1.
  - r==0 with no word emitted: cannot occur, since fill=0 always yields r=3.
  - r>0 and no word emitted this cycle (fill was 0): load a padded word (residual bytes, rest PAD_BYTE) with tlast=1 directly; fill=0.
  - r>0 and a word emitted this cycle (fill 2 or 3 before): emit the full word with tlast=0, then go to FLUSH.
- FLUSH state:
  - in_ready=0.
  - When the output register frees, load the padded residual word with tlast=1; fill=0; return to RUN. Exactly one cycle in FLUSH when the sink is ready.
- SOF with fill!=0 (malformed upstream): residual bytes dropped, sof_misalign pulses for 1 cycle, then packing restarts at the SOF pixel as if fill=0.
- in_valid with in_ready=0: no state change. Upstream holds its data.
- Simultaneous sink accept and new pixel accept in the same cycle: supported; full throughput of 1 pixel/cycle in RUN.
- Flags are sampled only on accepted pixels.

Test Plan:
- No EOL, P0..P3 = (11,12,13),(21,22,23),(31,32,33),(41,42,43), tready=1 -> words 0x21131211, 0x32312322, 0x43424133. tlast=0. in_ready never low.
- Line width 1: P0 with eol=1, sof=1 -> one word 0x00131211 with tlast=1, tuser=1. fill returns to 0.
- Line width 2: P0, then P1 with eol -> 0x21131211 (tlast=0), then 0x00002322 (tlast=1). in_ready low exactly 1 cycle (FLUSH).
- Backpressure: run the 4-pixel stream with tready=0 for 5 cycles after the first word -> tdata held at 0x21131211; in_ready=0; no bytes lost; remaining words in order once tready=1.
- SOF misalign: P0 (no eol), then P1 with sof=1 -> sof_misalign pulses once; the next emitted word begins with P1 bytes and has tuser=1.
- Reset mid-line: assert areset with fill=2 and tvalid=1 -> outputs are 0 immediately. After release, a line-width-1 pixel produces 0x00<b><g><r> with no stale bytes.
